// File: rtl/instr_mem_loadable_pkg.sv
// instr_mem_loadable_pkg
// Shared constants for the loadable instruction memory: the LED opcode used
// to build the clear/default instruction, and the sequencer state encodings.
package instr_mem_loadable_pkg;

   localparam int OPCODE_WIDTH  = 4;
   localparam int OPERAND_WIDTH = 24;
   localparam int INSTR_WIDTH   = OPCODE_WIDTH + OPERAND_WIDTH;

   // LED opcode of the lab CPU instruction set
   localparam logic [OPCODE_WIDTH-1:0] OP_LED = 4'h3;

   // Word written by the clear sweep and returned for out-of-range fetches
   localparam logic [INSTR_WIDTH-1:0] INSTR_DEFAULT = {OP_LED, 24'b10101010};

   // Sequencer states: clear sweep after reset, normal fetch, program load
   typedef enum logic [1:0] {
      IM_CLEAR = 2'd0,
      IM_RUN   = 2'd1,
      IM_LOAD  = 2'd2
   } im_state_e;

endpackage

// File: rtl/instr_mem_loadable_ram.sv
// instr_ram
// Plain DEPTH x DATA_WIDTH storage: one synchronous write port, one
// synchronous read port with read enable. No reset on the array or the read
// register; the owning sequencer clears the array and masks the read data.
module instr_ram
   import instr_mem_loadable_pkg::*;
#(
   parameter int DATA_WIDTH = 28,
   parameter int DEPTH      = 256,
   parameter int PTR_W      = 8
) (
   input  logic                  Clock,
   input  logic                  we,
   input  logic [PTR_W-1:0]      waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [PTR_W-1:0]      raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // Write port: one word per cycle when enabled
   always_ff @(posedge Clock) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read port: registered, holds its value when no read is requested
   always_ff @(posedge Clock) begin
      if (re) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable
// Runtime-loadable instruction memory for the lab CPU. After reset the
// sequencer sweeps DEFAULT_WORD through every word (CLEAR), then serves
// 1-cycle-latency fetches (RUN). A host loader can start a burst at any time
// in RUN; beats are written at an auto-incrementing pointer that wraps at
// DEPTH-1 (LOAD). Fetches at or beyond DEPTH return DEFAULT_WORD.
module instr_mem_loadable
   import instr_mem_loadable_pkg::*;
#(
   parameter int DATA_WIDTH = 28,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 256,
   parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(INSTR_DEFAULT)
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iFetchEn,
   input  logic [ADDR_WIDTH-1:0] iFetchAddr,
   output logic [DATA_WIDTH-1:0] oInstruction,
   output logic                  oValid,
   input  logic                  iLoadStart,
   input  logic [ADDR_WIDTH-1:0] iLoadAddr,
   input  logic                  iLoadValid,
   input  logic [DATA_WIDTH-1:0] iLoadData,
   input  logic                  iLoadLast,
   output logic                  oLoadReady,
   output logic                  oLoadDone,
   output logic                  oLoadWrap,
   output logic                  oBusy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(DEPTH - 1);
   // Depth widened by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly
   localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

   im_state_e             state_r;
   im_state_e             state_s;
   logic [PTR_W-1:0]      clr_ptr_r;
   logic [PTR_W-1:0]      ld_ptr_r;
   logic                  in_range_r;
   logic                  valid_r;
   logic                  ready_r;
   logic                  done_r;
   logic                  wrap_r;
   logic                  busy_r;

   logic                  fetch_acc_s;
   logic                  fetch_hit_s;
   logic                  fetch_in_range_s;
   logic                  beat_acc_s;
   logic                  load_start_s;
   logic                  we_s;
   logic                  ram_we_s;
   logic [PTR_W-1:0]      waddr_s;
   logic [DATA_WIDTH-1:0] wdata_s;
   logic [DATA_WIDTH-1:0] rdata_s;
   logic [PTR_W-1:0]      ld_base_s;
   logic [PTR_W-1:0]      ld_ptr_next_s;
   logic [PTR_W-1:0]      clr_ptr_next_s;

   // Full-width range check: upper address bits never alias into the array
   assign fetch_in_range_s = ({1'b0, iFetchAddr} < DEPTH_EXT);
   assign fetch_hit_s      = fetch_acc_s & fetch_in_range_s;

   // Burst start address folded into the implemented depth
   assign ld_base_s = PTR_W'({1'b0, iLoadAddr} % DEPTH_EXT);

   // Pointer successors, wrapping at the last implemented word
   assign ld_ptr_next_s  = (ld_ptr_r  == LAST_PTR) ? '0 : ld_ptr_r  + PTR_W'(1);
   assign clr_ptr_next_s = (clr_ptr_r == LAST_PTR) ? '0 : clr_ptr_r + PTR_W'(1);

   // No array writes land in a reset cycle
   assign ram_we_s = we_s & ~Reset;

   // Sequencer next state and per-cycle write/read control
   always_comb begin
      state_s      = state_r;
      we_s         = 1'b0;
      waddr_s      = clr_ptr_r;
      wdata_s      = DEFAULT_WORD;
      fetch_acc_s  = 1'b0;
      beat_acc_s   = 1'b0;
      load_start_s = 1'b0;
      case (state_r)
         IM_CLEAR: begin
            we_s = 1'b1;
            if (clr_ptr_r == LAST_PTR) begin
               state_s = IM_RUN;
            end else begin
               state_s = IM_CLEAR;
            end
         end
         IM_RUN: begin
            // A load start wins over a fetch in the same cycle
            if (iLoadStart) begin
               load_start_s = 1'b1;
               state_s      = IM_LOAD;
            end else begin
               fetch_acc_s = iFetchEn;
               state_s     = IM_RUN;
            end
         end
         IM_LOAD: begin
            beat_acc_s = iLoadValid & ready_r;
            we_s       = beat_acc_s;
            waddr_s    = ld_ptr_r;
            wdata_s    = iLoadData;
            if (beat_acc_s && iLoadLast) begin
               state_s = IM_RUN;
            end else begin
               state_s = IM_LOAD;
            end
         end
         default: begin
            state_s = IM_CLEAR;
         end
      endcase
   end

   // Sequencer state register; reset always restarts the clear sweep
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_r <= IM_CLEAR;
      end else begin
         state_r <= state_s;
      end
   end

   // Clear sweep pointer, advances once per CLEAR cycle
   always_ff @(posedge Clock) begin
      if (Reset) begin
         clr_ptr_r <= '0;
      end else if (state_r == IM_CLEAR) begin
         clr_ptr_r <= clr_ptr_next_s;
      end
   end

   // Load pointer: seeded by a burst start, advanced by each accepted beat
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ld_ptr_r <= '0;
      end else if (load_start_s) begin
         ld_ptr_r <= ld_base_s;
      end else if (beat_acc_s) begin
         ld_ptr_r <= ld_ptr_next_s;
      end
   end

   // Remember whether the last accepted fetch hit the array or fell outside it
   always_ff @(posedge Clock) begin
      if (Reset) begin
         in_range_r <= 1'b0;
      end else if (fetch_acc_s) begin
         in_range_r <= fetch_in_range_s;
      end
   end

   // Registered status outputs derived from the sequencer decisions
   always_ff @(posedge Clock) begin
      if (Reset) begin
         valid_r <= 1'b0;
         ready_r <= 1'b0;
         done_r  <= 1'b0;
         wrap_r  <= 1'b0;
         busy_r  <= 1'b1;
      end else begin
         valid_r <= fetch_acc_s;
         ready_r <= (state_s == IM_LOAD);
         done_r  <= beat_acc_s & iLoadLast;
         busy_r  <= (state_s != IM_RUN);
         if (load_start_s) begin
            wrap_r <= 1'b0;
         end else if (beat_acc_s && (ld_ptr_r == LAST_PTR)) begin
            wrap_r <= 1'b1;
         end
      end
   end

   instr_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_W      (PTR_W)
   ) u_ram (
      .Clock (Clock),
      .we    (ram_we_s),
      .waddr (waddr_s),
      .wdata (wdata_s),
      .re    (fetch_hit_s),
      .raddr (iFetchAddr[PTR_W-1:0]),
      .rdata (rdata_s)
   );

   // Both mux inputs are registers that only move on an accepted fetch, so the
   // word holds between fetches and reads DEFAULT_WORD after reset
   assign oInstruction = in_range_r ? rdata_s : DEFAULT_WORD;
   assign oValid       = valid_r;
   assign oLoadReady   = ready_r;
   assign oLoadDone    = done_r;
   assign oLoadWrap    = wrap_r;
   assign oBusy        = busy_r;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable
// Directed scenarios plus randomized fetch/load traffic. A word-array model
// of the memory and a simple mode tracker predict every output each cycle.
module tb_instr_mem_loadable;

   localparam int DW    = 28;
   localparam int AW    = 16;
   localparam int DEPTH = 256;
   localparam logic [DW-1:0] DEF = 28'h30000AA;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          iFetchEn;
   logic [AW-1:0] iFetchAddr;
   logic [DW-1:0] oInstruction;
   logic          oValid;
   logic          iLoadStart;
   logic [AW-1:0] iLoadAddr;
   logic          iLoadValid;
   logic [DW-1:0] iLoadData;
   logic          iLoadLast;
   logic          oLoadReady;
   logic          oLoadDone;
   logic          oLoadWrap;
   logic          oBusy;

   int checks   = 0;
   int failures = 0;
   int printed  = 0;

   instr_mem_loadable #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .iFetchEn     (iFetchEn),
      .iFetchAddr   (iFetchAddr),
      .oInstruction (oInstruction),
      .oValid       (oValid),
      .iLoadStart   (iLoadStart),
      .iLoadAddr    (iLoadAddr),
      .iLoadValid   (iLoadValid),
      .iLoadData    (iLoadData),
      .iLoadLast    (iLoadLast),
      .oLoadReady   (oLoadReady),
      .oLoadDone    (oLoadDone),
      .oLoadWrap    (oLoadWrap),
      .oBusy        (oBusy)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (printed < 40) begin
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
         end
         printed++;
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 = clearing, 1 = running, 2 = loading
   logic [DW-1:0] mem_m [DEPTH];
   int            mode     = 0;
   int            clr_left = 0;
   int            wp       = 0;
   bit            model_on = 1'b0;
   logic [DW-1:0] exp_instr;
   bit            exp_valid, exp_ready, exp_done, exp_wrap, exp_busy;

   // Model update on each rising edge, comparison on the following falling edge
   initial begin
      forever begin
         @(posedge Clock);
         exp_valid = 1'b0;
         exp_done  = 1'b0;
         if (Reset) begin
            model_on  = 1'b1;
            mode      = 0;
            clr_left  = DEPTH;
            exp_instr = DEF;
            exp_wrap  = 1'b0;
         end else if (mode == 0) begin
            mem_m[DEPTH - clr_left] = DEF;
            clr_left--;
            if (clr_left == 0) mode = 1;
         end else if (mode == 1) begin
            if (iLoadStart) begin
               wp       = int'(iLoadAddr) % DEPTH;
               exp_wrap = 1'b0;
               mode     = 2;
            end else if (iFetchEn) begin
               exp_instr = (int'(iFetchAddr) < DEPTH) ? mem_m[int'(iFetchAddr)] : DEF;
               exp_valid = 1'b1;
            end
         end else begin
            if (iLoadValid) begin
               mem_m[wp] = iLoadData;
               if (wp == DEPTH - 1) begin
                  wp       = 0;
                  exp_wrap = 1'b1;
               end else begin
                  wp++;
               end
               if (iLoadLast) begin
                  mode     = 1;
                  exp_done = 1'b1;
               end
            end
         end
         exp_busy  = (mode != 1);
         exp_ready = (mode == 2);
         @(negedge Clock);
         if (model_on) begin
            check("instr", 32'(oInstruction), 32'(exp_instr));
            check("valid", 32'(oValid),       32'(exp_valid));
            check("busy",  32'(oBusy),        32'(exp_busy));
            check("ready", 32'(oLoadReady),   32'(exp_ready));
            check("done",  32'(oLoadDone),    32'(exp_done));
            check("wrap",  32'(oLoadWrap),    32'(exp_wrap));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(negedge Clock);
   endtask

   task automatic idle();
      iFetchEn   = 1'b0;
      iLoadStart = 1'b0;
      iLoadValid = 1'b0;
      iLoadLast  = 1'b0;
   endtask

   // Pulse reset for one edge, then count falling edges with oBusy high
   task automatic reset_and_clear(output int busy_n, output bit saw_done);
      idle();
      Reset = 1'b1;
      cyc();
      Reset    = 1'b0;
      busy_n   = 0;
      saw_done = 1'b0;
      while (oBusy && busy_n < 1000) begin
         busy_n++;
         if (oLoadDone) saw_done = 1'b1;
         cyc();
      end
   endtask

   task automatic fetch(input logic [AW-1:0] a);
      iFetchEn   = 1'b1;
      iFetchAddr = a;
      cyc();
   endtask

   task automatic start_load(input logic [AW-1:0] a);
      iLoadStart = 1'b1;
      iLoadAddr  = a;
      cyc();
      iLoadStart = 1'b0;
   endtask

   task automatic beat(input bit v, input logic [DW-1:0] d, input bit last);
      iLoadValid = v;
      iLoadData  = d;
      iLoadLast  = last;
      cyc();
      iLoadValid = 1'b0;
      iLoadLast  = 1'b0;
   endtask

   task automatic random_load();
      int n;
      int k;
      n = $urandom_range(1, 6);
      iLoadStart = 1'b1;
      iLoadAddr  = AW'($urandom_range(0, 400));
      iFetchEn   = 1'($urandom_range(0, 1));
      iFetchAddr = AW'($urandom_range(0, DEPTH - 1));
      cyc();
      iLoadStart = 1'b0;
      k = 0;
      while (k < n) begin
         iLoadValid = 1'($urandom_range(0, 3) != 0);
         iLoadData  = DW'($urandom);
         iLoadLast  = (k == n - 1);
         iLoadStart = ($urandom_range(0, 7) == 0);
         iFetchEn   = 1'($urandom_range(0, 1));
         iLoadAddr  = AW'($urandom);
         cyc();
         if (iLoadValid) k++;
      end
      idle();
   endtask

   task automatic random_fetches();
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
         iFetchEn = 1'($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 3) != 0) begin
            iFetchAddr = AW'($urandom_range(0, DEPTH - 1));
         end else begin
            iFetchAddr = AW'($urandom);
         end
         cyc();
      end
      idle();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int busy_n;
      bit saw_done;
      Reset      = 1'b1;
      iFetchAddr = '0;
      iLoadAddr  = '0;
      iLoadData  = '0;
      idle();

      // 1: clear sweep length, then an ordinary fetch
      reset_and_clear(busy_n, saw_done);
      check("t1_busy_cycles", 32'(busy_n), 32'd256);
      fetch(16'd5);
      check("t1_fetch5", 32'(oInstruction), 32'(DEF));
      check("t1_valid", 32'(oValid), 32'd1);
      idle();
      cyc();
      check("t1_valid_drop", 32'(oValid), 32'd0);

      // 2: three-beat program, read back on consecutive cycles
      start_load(16'd0);
      check("t2_ready", 32'(oLoadReady), 32'd1);
      beat(1'b1, 28'h1000FA0, 1'b0);
      beat(1'b1, 28'h2070001, 1'b0);
      beat(1'b1, 28'h2030001, 1'b1);
      check("t2_done", 32'(oLoadDone), 32'd1);
      cyc();
      check("t2_done_pulse", 32'(oLoadDone), 32'd0);
      fetch(16'd0);
      check("t2_w0", 32'(oInstruction), 32'h1000FA0);
      fetch(16'd1);
      check("t2_w1", 32'(oInstruction), 32'h2070001);
      check("t2_v1", 32'(oValid), 32'd1);
      fetch(16'd2);
      check("t2_w2", 32'(oInstruction), 32'h2030001);
      check("t2_v2", 32'(oValid), 32'd1);

      // 3: out-of-range fetches, no aliasing of upper address bits
      fetch(16'd300);
      check("t3_addr300", 32'(oInstruction), 32'(DEF));
      fetch(16'd258);
      check("t3_addr258", 32'(oInstruction), 32'(DEF));
      idle();

      // 4: burst crossing the top of memory
      start_load(16'd254);
      beat(1'b1, 28'hA0000FE, 1'b0);
      check("t4_wrap_b1", 32'(oLoadWrap), 32'd0);
      beat(1'b1, 28'hA0000FF, 1'b0);
      beat(1'b1, 28'hA000100, 1'b0);
      check("t4_wrap_b3", 32'(oLoadWrap), 32'd1);
      beat(1'b1, 28'hA000101, 1'b1);
      fetch(16'd254);
      check("t4_w254", 32'(oInstruction), 32'hA0000FE);
      fetch(16'd255);
      check("t4_w255", 32'(oInstruction), 32'hA0000FF);
      fetch(16'd0);
      check("t4_w0", 32'(oInstruction), 32'hA000100);
      fetch(16'd1);
      check("t4_w1", 32'(oInstruction), 32'hA000101);
      check("t4_wrap_sticky", 32'(oLoadWrap), 32'd1);
      idle();

      // 5: bubbles between beats; new start clears wrap
      start_load(16'd10);
      check("t5_wrap_cleared", 32'(oLoadWrap), 32'd0);
      beat(1'b1, 28'h5550001, 1'b0);
      beat(1'b0, 28'hBADBAD1, 1'b0);
      beat(1'b0, 28'hBADBAD2, 1'b0);
      beat(1'b1, 28'h5550002, 1'b1);
      check("t5_done", 32'(oLoadDone), 32'd1);
      fetch(16'd10);
      check("t5_w10", 32'(oInstruction), 32'h5550001);
      fetch(16'd11);
      check("t5_w11", 32'(oInstruction), 32'h5550002);
      fetch(16'd12);
      check("t5_w12", 32'(oInstruction), 32'(DEF));
      // load start and fetch together: fetch is dropped
      iFetchEn   = 1'b1;
      iFetchAddr = 16'd10;
      iLoadStart = 1'b1;
      iLoadAddr  = 16'd20;
      cyc();
      idle();
      check("t5_start_drops_fetch", 32'(oValid), 32'd0);
      check("t5_start_busy", 32'(oBusy), 32'd1);
      beat(1'b1, 28'h5550014, 1'b1);
      fetch(16'd20);
      check("t5_w20", 32'(oInstruction), 32'h5550014);
      idle();

      // 6: reset in the middle of a burst
      start_load(16'd40);
      beat(1'b1, 28'h6660028, 1'b0);
      beat(1'b1, 28'h6660029, 1'b0);
      reset_and_clear(busy_n, saw_done);
      check("t6_busy_cycles", 32'(busy_n), 32'd256);
      check("t6_no_done", 32'(saw_done), 32'd0);
      fetch(16'd40);
      check("t6_w40", 32'(oInstruction), 32'(DEF));
      fetch(16'd41);
      check("t6_w41", 32'(oInstruction), 32'(DEF));
      fetch(16'd0);
      check("t6_w0", 32'(oInstruction), 32'(DEF));
      idle();

      // Randomized mix of loads and fetches against the model
      for (int it = 0; it < 80; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            random_load();
         end else begin
            random_fetches();
         end
      end
      // Sweep every in-range word once
      for (int a = 0; a < DEPTH; a++) begin
         fetch(AW'(a));
      end
      idle();
      cyc();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Bound on total run time
   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1);
   end

endmodule
